clk_prog_ctrl: RTL and testbench
================================

# clk_prog_ctrl

Sequencer for the DCM_CLKGEN-based programmable clock generators. It accepts frequency requests as (CMT index, M−1, D−1) and serializes the LoadD, LoadM and GO commands onto the shared progen/progdata/progclk bus. It then waits for the generator to report completion; if completion never comes, it resets the PLL and reports an error. It sits on the IFCLK domain between the host command decoder and the clocks block.

## Interface
Parameters:
- NUM_CMT, 2, number of programmable generators sharing the bus; one progen bit each
- CMT_W, 1, width of req_cmt; satisfies 2**CMT_W >= NUM_CMT
- PROG_DIV, 2, IFCLK cycles per progclk half-period; must be ≥1
- TIMEOUT, 65536, IFCLK cycles allowed in WAIT_DONE
- RST_CYCLES, 16, pll_reset pulse width in IFCLK cycles

Ports:
- IFCLK  in  1  sole clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request strobe
- req_ready  out  1  high only in IDLE
- req_cmt  in  CMT_W  target generator index
- req_m  in  8  M−1
- req_d  in  8  D−1
- progen  out  NUM_CMT  one-hot enable to the selected generator
- progdata  out  1  serial command bit
- progclk  out  1  programming clock, registered
- progdone_inv  in  1  low = generator done; asynchronous to IFCLK
- pll_reset  out  1  reset pulse to the generators
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse when a request completes (success or error)
- err  out  2  00 OK, 01 TIMEOUT, 10 BAD_CMT, 11 BAD_PARAM; valid with done, held until the next accept

## Operation
- **States:** IDLE → LOAD_D → GAP1 → LOAD_M → GAP2 → GO → SETTLE → WAIT_DONE → IDLE.
  - On timeout, WAIT_DONE → RESET_PLL → IDLE.
  - On validation failure, IDLE → REJECT → IDLE.
- **Accept:** a request is accepted on req_valid & req_ready. All request fields are latched on accept.
- **Validation** is done in IDLE on the accept cycle:
  - req_cmt ≥ NUM_CMT → BAD_CMT.
  - req_m == 0 (i.e. M = 1) → BAD_PARAM.
  - BAD_CMT takes priority over BAD_PARAM.
  - A rejected request never asserts progen.
- **Bit slots:** one slot equals one full progclk period.
- **LOAD_D:** 10 slots with progen[cmt] high. progdata is 1, then 0, then req_d[0..7] LSB first.
- **GAP1 / GAP2:** 1 slot each with progen low and progdata 0.
- **LOAD_M:** 10 slots with progen[cmt] high. progdata is 1, then 1, then req_m[0..7] LSB first.
- **GO:** 1 slot with progen[cmt] high and progdata 0.
- **SETTLE:** 4 slots with progen low. This lets progdone deassert before it is sampled.
- **WAIT_DONE:** progdone_inv goes through a 2-FF synchronizer.
  - Synced value 0 → done pulse, err = OK, return to IDLE.
  - The cycle counter reaching TIMEOUT → RESET_PLL.
- **RESET_PLL:** pll_reset is high for RST_CYCLES cycles, then done pulses with err = TIMEOUT.
- **Requests while busy** are not accepted; req_ready stays low.

## Timing
- **Reset values:** progen = 0, progdata = 0, progclk = 0, pll_reset = 0, busy = 0, done = 0, err = 00, req_ready = 0. req_ready rises on the first IFCLK edge after rst_n deasserts.
- **progclk generation:** progclk toggles every PROG_DIV IFCLK cycles, and only while the state is one of LOAD_D through SETTLE. It is held 0 otherwise.
- **Output update timing:** progen and progdata change only on the IFCLK edge where progclk goes 1→0. The generators sample on the progclk rising edge.
- **Programming length:** LOAD_D through GO take 23 slots, i.e. 46·PROG_DIV IFCLK cycles. SETTLE adds 8·PROG_DIV cycles.
- **First slot:** starts on the IFCLK edge after accept, with progclk = 0 at that point.
- **REJECT:** lasts 1 cycle. done and err are asserted on the cycle after accept.
- **Async reset mid-operation:** all outputs drop to their reset values immediately. A partially loaded generator is left unprogrammed; the host re-issues the request.
- **Counter widths:** the timeout counter is $clog2(TIMEOUT+1) bits and saturates, never wrapping. The slot counter is 4 bits.

## Structure
- **Package clk_prog_pkg** holds:
  - the state enum;
  - the err code constants (ERR_OK, ERR_TIMEOUT, ERR_BAD_CMT, ERR_BAD_PARAM);
  - the command prefixes: LOADD = 2'b01 and LOADM = 2'b11, sent LSB first;
  - the SETTLE_SLOTS = 4 constant.
- **Sub-module clk_prog_shifter** contains the progclk divider, slot strobe and 10-bit LSB-first serializer. Its interface is load/word/len in and slot_end/shift_done out.

## Test plan
- **Nominal programming.** PROG_DIV = 1, cmt = 0, M−1 = 8'h1B, D−1 = 8'h03, progdone_inv driven low 100 cycles after GO.
  - Expect progdata sequence 1,0,1,1,0,0,0,0,0,0 / 1,1,1,1,0,1,1,0,0,0 / 0 with progen[0] only.
  - Expect done with err = 00.
- **Timeout.** TIMEOUT = 200, progdone_inv held high.
  - Expect pll_reset high for exactly 16 cycles, then done with err = 01, then req_ready = 1.
- **Rejects.** req_cmt = 3 with NUM_CMT = 2 → err = 10. req_m = 0 → err = 11.
  - Both: progen never asserted, done on the cycle after accept.
- **Busy.** req_valid held through a whole transaction.
  - Exactly one accept per transaction; the second request starts only after done.
- **Reset mid-LOAD_M.** rst_n pulsed low during LOAD_M.
  - All outputs reach reset values asynchronously; req_ready is 1 one cycle after release.
- **Bus timing.** PROG_DIV = 3.
  - progclk period is 6 cycles; progen/progdata change only on progclk falling edges.
  - Total programming time is 138 cycles.

Source files
------------

// File: rtl/clk_prog_pkg.sv
`default_nettype none
// ============================================================================
// clk_prog_pkg : shared types and command constants for the clock programmer
// Rev 1.0
// ============================================================================
package clk_prog_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_LOAD_D    = 4'd1,
        S_GAP1      = 4'd2,
        S_LOAD_M    = 4'd3,
        S_GAP2      = 4'd4,
        S_GO        = 4'd5,
        S_SETTLE    = 4'd6,
        S_WAIT_DONE = 4'd7,
        S_RESET_PLL = 4'd8,
        S_REJECT    = 4'd9
    } state_e;

    localparam logic [1:0] ERR_OK        = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b01;
    localparam logic [1:0] ERR_BAD_CMT   = 2'b10;
    localparam logic [1:0] ERR_BAD_PARAM = 2'b11;

    localparam logic [1:0] LOADD = 2'b01;
    localparam logic [1:0] LOADM = 2'b11;

    localparam logic [3:0] SETTLE_SLOTS = 4'd4;
    localparam logic [3:0] c_WORD_SLOTS = 4'd10;

    // Prefix occupies the low bits so it leaves the serializer first.
    function automatic logic [9:0] cmd_word(input logic [1:0] prefix, input logic [7:0] value);
        return {value, prefix};
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_prog_ctrl_if.sv
`default_nettype none
// ============================================================================
// clk_prog_ctrl_if : request handshake, programming bus and status bundle
// Rev 1.0
// ============================================================================
interface clk_prog_ctrl_if #(
    parameter int NUM_CMT = 2,
    parameter int CMT_W   = 1
) ();
    logic               req_valid;
    logic               req_ready;
    logic [CMT_W-1:0]   req_cmt;
    logic [7:0]         req_m;
    logic [7:0]         req_d;
    logic [NUM_CMT-1:0] progen;
    logic               progdata;
    logic               progclk;
    logic               progdone_inv;
    logic               pll_reset;
    logic               busy;
    logic               done;
    logic [1:0]         err;

    modport master (
        output req_valid, req_cmt, req_m, req_d, progdone_inv,
        input  req_ready, progen, progdata, progclk, pll_reset, busy, done, err
    );

    modport slave (
        input  req_valid, req_cmt, req_m, req_d, progdone_inv,
        output req_ready, progen, progdata, progclk, pll_reset, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/clk_prog_shifter.sv
`default_nettype none
// ============================================================================
// clk_prog_shifter : progclk divider, slot strobe and LSB-first serializer
// Rev 1.0
// ============================================================================
module clk_prog_shifter #(
    parameter int PROG_DIV = 2
) (
    input  wire logic       IFCLK,
    input  wire logic       rst_n,
    input  wire logic       en,
    input  wire logic       load,
    input  wire logic [9:0] word,
    input  wire logic [3:0] len,
    output logic            progclk,
    output logic            progdata,
    output logic            slot_end,
    output logic            shift_done
);
    localparam int DIV_W = (PROG_DIV > 1) ? $clog2(PROG_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic             r_progclk;
    logic [9:0]       r_sr;
    logic [3:0]       r_cnt;
    logic             w_tick;

    assign w_tick     = en && (r_div == DIV_W'(PROG_DIV - 1));
    assign slot_end   = w_tick && r_progclk;
    assign shift_done = slot_end && (r_cnt == 4'd1);
    assign progclk    = r_progclk;
    assign progdata   = r_sr[0];

    // A load always lands on a slot boundary, so progclk restarts low.
    always_ff @(posedge IFCLK or negedge rst_n) begin
        if (!rst_n) begin
            r_div     <= '0;
            r_progclk <= 1'b0;
            r_sr      <= '0;
            r_cnt     <= '0;
        end else if (load) begin
            r_div     <= '0;
            r_progclk <= 1'b0;
            r_sr      <= word;
            r_cnt     <= len;
        end else if (!en) begin
            r_div     <= '0;
            r_progclk <= 1'b0;
        end else begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            if (w_tick) begin
                r_progclk <= ~r_progclk;
            end
            if (slot_end) begin
                r_sr <= {1'b0, r_sr[9:1]};
                if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/clk_prog_ctrl.sv
`default_nettype none
// ============================================================================
// clk_prog_ctrl : serializes LoadD/LoadM/GO onto the DCM_CLKGEN program bus
// Rev 1.0
// ============================================================================
module clk_prog_ctrl
    import clk_prog_pkg::*;
#(
    parameter int NUM_CMT    = 2,
    parameter int CMT_W      = 1,
    parameter int PROG_DIV   = 2,
    parameter int TIMEOUT    = 65536,
    parameter int RST_CYCLES = 16
) (
    input  wire logic      IFCLK,
    input  wire logic      rst_n,
    clk_prog_ctrl_if.slave bus
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int RST_W = $clog2(RST_CYCLES + 1);

    state_e             r_state, w_next;
    logic [CMT_W-1:0]   r_cmt, w_sel;
    logic [7:0]         r_m;
    logic [1:0]         r_sync;
    logic [TMO_W-1:0]   r_tmo;
    logic [RST_W-1:0]   r_rcnt;
    logic [NUM_CMT-1:0] r_progen, w_progen_nxt;
    logic               r_pll_reset, r_done, r_ready, w_done_nxt;
    logic [1:0]         r_err, w_err_nxt;
    logic               w_accept, w_bad_cmt, w_bad_m, w_step;
    logic               w_en, w_load, w_slot_end, w_shift_done;
    logic [9:0]         w_word;
    logic [3:0]         w_len;

    assign w_accept  = bus.req_valid && r_ready;
    assign w_bad_cmt = 32'(bus.req_cmt) >= 32'(NUM_CMT);
    assign w_bad_m   = (bus.req_m == 8'd0);
    assign w_step    = w_slot_end && w_shift_done;
    assign w_en      = r_state inside {S_LOAD_D, S_GAP1, S_LOAD_M, S_GAP2, S_GO, S_SETTLE};

    always_ff @(posedge IFCLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:      if (w_accept) w_next = (w_bad_cmt || w_bad_m) ? S_REJECT : S_LOAD_D;
            S_LOAD_D:    if (w_step) w_next = S_GAP1;
            S_GAP1:      if (w_step) w_next = S_LOAD_M;
            S_LOAD_M:    if (w_step) w_next = S_GAP2;
            S_GAP2:      if (w_step) w_next = S_GO;
            S_GO:        if (w_step) w_next = S_SETTLE;
            S_SETTLE:    if (w_step) w_next = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (!r_sync[1]) begin
                    w_next = S_IDLE;
                end else if (r_tmo == TMO_W'(TIMEOUT)) begin
                    w_next = S_RESET_PLL;
                end
            end
            S_RESET_PLL: if (r_rcnt == RST_W'(RST_CYCLES - 1)) w_next = S_IDLE;
            S_REJECT:    w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state and registered, so progen and
    // progdata move on the same edge the serializer reloads.
    always_comb begin
        w_load = (w_next != r_state) &&
                 (w_next inside {S_LOAD_D, S_GAP1, S_LOAD_M, S_GAP2, S_GO, S_SETTLE});
        w_word = '0;
        w_len  = 4'd1;
        case (w_next)
            S_LOAD_D: begin w_word = cmd_word(LOADD, bus.req_d); w_len = c_WORD_SLOTS; end
            S_LOAD_M: begin w_word = cmd_word(LOADM, r_m);       w_len = c_WORD_SLOTS; end
            S_SETTLE: w_len = SETTLE_SLOTS;
            default:  ;
        endcase
        w_sel = (r_state == S_IDLE) ? bus.req_cmt : r_cmt;
        for (int i = 0; i < NUM_CMT; i++) begin
            w_progen_nxt[i] = (w_next inside {S_LOAD_D, S_LOAD_M, S_GO}) && (w_sel == CMT_W'(i));
        end
        w_done_nxt = (w_next == S_REJECT) ||
                     ((r_state inside {S_WAIT_DONE, S_RESET_PLL}) && (w_next == S_IDLE));
        w_err_nxt  = r_err;
        if (r_state == S_IDLE && w_accept) begin
            w_err_nxt = w_bad_cmt ? ERR_BAD_CMT : (w_bad_m ? ERR_BAD_PARAM : ERR_OK);
        end else if (r_state == S_RESET_PLL && w_next == S_IDLE) begin
            w_err_nxt = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge IFCLK or negedge rst_n) begin
        if (!rst_n) begin
            r_progen    <= '0;
            r_pll_reset <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= ERR_OK;
            r_ready     <= 1'b0;
            r_sync      <= 2'b11;
            r_cmt       <= '0;
            r_m         <= '0;
            r_tmo       <= '0;
            r_rcnt      <= '0;
        end else begin
            r_progen    <= w_progen_nxt;
            r_pll_reset <= (w_next == S_RESET_PLL);
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_ready     <= (w_next == S_IDLE);
            r_sync      <= {r_sync[0], bus.progdone_inv};
            if (r_state == S_IDLE && w_accept) begin
                r_cmt <= bus.req_cmt;
                r_m   <= bus.req_m;
            end
            if (r_state != S_WAIT_DONE) begin
                r_tmo <= '0;
            end else if (r_tmo != TMO_W'(TIMEOUT)) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
            r_rcnt <= (r_state == S_RESET_PLL) ? r_rcnt + RST_W'(1) : '0;
        end
    end

    clk_prog_shifter #(
        .PROG_DIV (PROG_DIV)
    ) u_shifter (
        .IFCLK      (IFCLK),
        .rst_n      (rst_n),
        .en         (w_en),
        .load       (w_load),
        .word       (w_word),
        .len        (w_len),
        .progclk    (bus.progclk),
        .progdata   (bus.progdata),
        .slot_end   (w_slot_end),
        .shift_done (w_shift_done)
    );

    assign bus.progen    = r_progen;
    assign bus.pll_reset = r_pll_reset;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.req_ready = r_ready;
    assign bus.busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_clk_prog_ctrl.sv
`default_nettype none
// Bench for clk_prog_ctrl: scoreboarded bit stream and completion codes on a
// PROG_DIV=1 instance, bus timing on a PROG_DIV=3 instance.
`timescale 1ns/1ps
module tb_clk_prog_ctrl;

    logic IFCLK = 1'b0;
    logic rst_n = 1'b0;
    always #5 IFCLK = ~IFCLK;

    clk_prog_ctrl_if #(.NUM_CMT(2), .CMT_W(2)) bus1 ();
    clk_prog_ctrl_if #(.NUM_CMT(2), .CMT_W(2)) bus3 ();

    clk_prog_ctrl #(.NUM_CMT(2), .CMT_W(2), .PROG_DIV(1), .TIMEOUT(200), .RST_CYCLES(16)) dut1 (
        .IFCLK (IFCLK), .rst_n (rst_n), .bus (bus1.slave)
    );
    clk_prog_ctrl #(.NUM_CMT(2), .CMT_W(2), .PROG_DIV(3), .TIMEOUT(200), .RST_CYCLES(16)) dut3 (
        .IFCLK (IFCLK), .rst_n (rst_n), .bus (bus3.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] exp_bits_q[$];  // {progen, progdata} at each progclk rise
    logic [1:0] exp_err_q[$];

    // Scoreboard monitor for the PROG_DIV=1 instance
    logic pclk_q = 1'b0;
    always @(negedge IFCLK) begin
        logic [2:0] e;
        logic [1:0] ee;
        if (bus1.progclk === 1'b1 && pclk_q === 1'b0) begin
            n_tests++;
            if (exp_bits_q.size() == 0) begin
                n_fail++;
                $display("FAIL bit_unexpected: got progen=%b progdata=%b, expected no progclk rise", bus1.progen, bus1.progdata);
            end else begin
                e = exp_bits_q.pop_front();
                if ({bus1.progen, bus1.progdata} !== e) begin
                    n_fail++;
                    $display("FAIL bit_slot: got progen/progdata=%b, expected %b (t=%0t)", {bus1.progen, bus1.progdata}, e, $time);
                end
            end
        end
        pclk_q = bus1.progclk;
        if (bus1.done === 1'b1) begin
            n_tests++;
            if (exp_err_q.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected: got done with err=%b, expected no done", bus1.err);
            end else begin
                ee = exp_err_q.pop_front();
                if (bus1.err !== ee) begin
                    n_fail++;
                    $display("FAIL err_code: got %b, expected %b", bus1.err, ee);
                end
            end
        end
    end

    task automatic push_txn(input logic [1:0] cmt, input logic [7:0] m, input logic [7:0] d, input logic [1:0] e);
        logic [1:0] pe;
        logic [9:0] wd;
        logic [9:0] wm;
        exp_err_q.push_back(e);
        if (e == 2'b00 || e == 2'b01) begin
            pe = (cmt == 2'd0) ? 2'b01 : 2'b10;
            wd = {d, 1'b0, 1'b1};
            wm = {m, 1'b1, 1'b1};
            for (int i = 0; i < 10; i++) exp_bits_q.push_back({pe, wd[i]});
            exp_bits_q.push_back(3'b000);
            for (int i = 0; i < 10; i++) exp_bits_q.push_back({pe, wm[i]});
            exp_bits_q.push_back(3'b000);
            exp_bits_q.push_back({pe, 1'b0});
            for (int i = 0; i < 4; i++) exp_bits_q.push_back(3'b000);
        end
    endtask

    // Returns at the first negedge after the accept edge.
    task automatic send(input logic [1:0] cmt, input logic [7:0] m, input logic [7:0] d,
                        input logic [1:0] e, output bit ok);
        int n;
        @(negedge IFCLK);
        bus1.req_valid = 1'b1;
        bus1.req_cmt   = cmt;
        bus1.req_m     = m;
        bus1.req_d     = d;
        n = 0;
        while (bus1.req_ready !== 1'b1 && n < 500) begin
            @(negedge IFCLK);
            n++;
        end
        n_tests++;
        if (bus1.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_wait: got req_ready=%b after %0d cycles, expected 1", bus1.req_ready, n);
            bus1.req_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        push_txn(cmt, m, d, e);
        @(negedge IFCLK);
        bus1.req_valid = 1'b0;
        ok = 1'b1;
    endtask

    task automatic wait_done(input int limit, input string name);
        int n;
        n = 0;
        while (bus1.done !== 1'b1 && n < limit) begin
            @(negedge IFCLK);
            n++;
        end
        n_tests++;
        if (bus1.done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done_wait: got done=%b after %0d cycles, expected 1", name, bus1.done, n);
        end
    endtask

    task automatic test_reset();
        bus1.req_valid = 1'b0; bus1.req_cmt = '0; bus1.req_m = '0; bus1.req_d = '0;
        bus1.progdone_inv = 1'b1;
        bus3.req_valid = 1'b0; bus3.req_cmt = '0; bus3.req_m = '0; bus3.req_d = '0;
        bus3.progdone_inv = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge IFCLK);
        n_tests++;
        if ({bus1.progen, bus1.progdata, bus1.progclk, bus1.pll_reset, bus1.busy,
             bus1.done, bus1.err, bus1.req_ready} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, expected all zero",
                     {bus1.progen, bus1.progdata, bus1.progclk, bus1.pll_reset, bus1.busy,
                      bus1.done, bus1.err, bus1.req_ready});
        end
        rst_n = 1'b1;
        @(negedge IFCLK);
        n_tests++;
        if (bus1.req_ready !== 1'b1 || bus3.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b%b, expected 11", bus1.req_ready, bus3.req_ready);
        end
    endtask

    task automatic test_nominal(input logic [1:0] cmt, input logic [7:0] m, input logic [7:0] d);
        bit ok;
        bus1.progdone_inv = 1'b1;
        send(cmt, m, d, 2'b00, ok);
        if (!ok) return;
        repeat (146) @(negedge IFCLK);
        n_tests++;
        if (bus1.busy !== 1'b1 || bus1.done !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_waiting: got busy=%b done=%b, expected busy=1 done=0", bus1.busy, bus1.done);
        end
        bus1.progdone_inv = 1'b0;
        wait_done(20, "nominal");
        @(negedge IFCLK);
        n_tests++;
        if ({bus1.done, bus1.req_ready, bus1.busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL nominal_after_done: got done/ready/busy=%b, expected 010",
                     {bus1.done, bus1.req_ready, bus1.busy});
        end
        bus1.progdone_inv = 1'b1;
    endtask

    task automatic test_reject();
        bit ok;
        bit saw_progen;
        logic [1:0] cmts[3] = '{2'd3, 2'd1, 2'd3};
        logic [7:0] ms[3]   = '{8'h10, 8'h00, 8'h00};
        logic [1:0] errs[3] = '{2'b10, 2'b11, 2'b10};
        saw_progen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send(cmts[k], ms[k], 8'h22, errs[k], ok);
            if (!ok) return;
            if (bus1.progen !== 2'b00) saw_progen = 1'b1;
            n_tests++;
            if (bus1.done !== 1'b1 || bus1.err !== errs[k]) begin
                n_fail++;
                $display("FAIL reject_%0d: got done=%b err=%b, expected done=1 err=%b", k, bus1.done, bus1.err, errs[k]);
            end
            for (int c = 0; c < 3; c++) begin
                @(negedge IFCLK);
                if (bus1.progen !== 2'b00) saw_progen = 1'b1;
            end
            n_tests++;
            if (bus1.done !== 1'b0 || bus1.req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reject_%0d_idle: got done=%b ready=%b, expected 0 1", k, bus1.done, bus1.req_ready);
            end
        end
        n_tests++;
        if (saw_progen) begin
            n_fail++;
            $display("FAIL reject_progen: got progen asserted, expected never");
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        bus1.progdone_inv = 1'b1;
        send(2'd0, 8'h10, 8'h02, 2'b01, ok);
        if (!ok) return;
        n = 0;
        while (bus1.pll_reset !== 1'b1 && n < 600) begin
            @(negedge IFCLK);
            n++;
        end
        n = 0;
        while (bus1.pll_reset === 1'b1 && n < 100) begin
            @(negedge IFCLK);
            n++;
        end
        n_tests++;
        if (n != 16) begin
            n_fail++;
            $display("FAIL timeout_pll_reset_width: got %0d cycles, expected 16", n);
        end
        n_tests++;
        if ({bus1.done, bus1.err, bus1.req_ready} !== 4'b1011) begin
            n_fail++;
            $display("FAIL timeout_done: got done/err/ready=%b, expected 1011", {bus1.done, bus1.err, bus1.req_ready});
        end
        @(negedge IFCLK);
    endtask

    task automatic test_back_to_back();
        int n, acc, dones, acc_before_done1, t_acc1, t_acc2, t_done1;
        bit drop;
        acc = 0; dones = 0; acc_before_done1 = 0; t_acc1 = 0; t_acc2 = 0; t_done1 = 0; drop = 1'b0;
        bus1.progdone_inv = 1'b0;
        @(negedge IFCLK);
        bus1.req_valid = 1'b1; bus1.req_cmt = 2'd1; bus1.req_m = 8'h42; bus1.req_d = 8'h24;
        for (n = 0; n < 500 && dones < 2; n++) begin
            if (bus1.done === 1'b1) begin
                dones++;
                if (dones == 1) begin
                    t_done1 = n;
                    acc_before_done1 = acc;
                end
            end
            if (bus1.req_valid && bus1.req_ready === 1'b1) begin
                acc++;
                if (acc == 1) t_acc1 = n; else t_acc2 = n;
                push_txn(2'd1, 8'h42, 8'h24, 2'b00);
                if (acc == 2) drop = 1'b1;
            end
            @(negedge IFCLK);
            if (drop) bus1.req_valid = 1'b0;
        end
        bus1.req_valid = 1'b0;
        n_tests++;
        if (acc != 2 || dones != 2) begin
            n_fail++;
            $display("FAIL busy_counts: got %0d accepts %0d dones, expected 2 2", acc, dones);
        end
        n_tests++;
        if (acc_before_done1 != 1) begin
            n_fail++;
            $display("FAIL busy_single_accept: got %0d accepts before first done, expected 1", acc_before_done1);
        end
        n_tests++;
        if (t_acc2 < t_done1 || (t_acc2 - t_acc1) < 54) begin
            n_fail++;
            $display("FAIL busy_second_start: got acc1=%0d done1=%0d acc2=%0d, expected acc2>=done1 and gap>=54",
                     t_acc1, t_done1, t_acc2);
        end
        bus1.progdone_inv = 1'b1;
        repeat (3) @(negedge IFCLK);
    endtask

    task automatic test_reset_mid();
        bit ok;
        send(2'd1, 8'h77, 8'h11, 2'b00, ok);
        if (!ok) return;
        repeat (28) @(negedge IFCLK);
        n_tests++;
        if (bus1.progen !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_mid_load_m: got progen=%b, expected 10", bus1.progen);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_bits_q.delete();
        exp_err_q.delete();
        n_tests++;
        if ({bus1.progen, bus1.progdata, bus1.progclk, bus1.pll_reset, bus1.busy,
             bus1.done, bus1.err, bus1.req_ready} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b, expected all zero",
                     {bus1.progen, bus1.progdata, bus1.progclk, bus1.pll_reset, bus1.busy,
                      bus1.done, bus1.err, bus1.req_ready});
        end
        @(negedge IFCLK);
        #1 rst_n = 1'b1;
        @(negedge IFCLK);
        n_tests++;
        if (bus1.req_ready !== 1'b1 || bus1.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_release: got ready=%b busy=%b, expected 1 0", bus1.req_ready, bus1.busy);
        end
    endtask

    task automatic test_bus_timing();
        int n, k, first_en, last_en_fall, last_rise, rises, bad_change, bad_period;
        logic prev_clk, prev_dat, prev_busy;
        logic [1:0] prev_en;
        bit got_done;
        first_en = -1; last_en_fall = -1; last_rise = -1; rises = 0; bad_change = 0; bad_period = 0;
        got_done = 1'b0;
        @(negedge IFCLK);
        bus3.req_valid = 1'b1; bus3.req_cmt = 2'd0; bus3.req_m = 8'h1B; bus3.req_d = 8'h03;
        n = 0;
        while (bus3.req_ready !== 1'b1 && n < 50) begin
            @(negedge IFCLK);
            n++;
        end
        prev_clk = bus3.progclk; prev_dat = bus3.progdata; prev_en = bus3.progen; prev_busy = bus3.busy;
        @(negedge IFCLK);
        bus3.req_valid = 1'b0;
        n_tests++;
        if (bus3.progclk !== 1'b0 || bus3.progen !== 2'b01) begin
            n_fail++;
            $display("FAIL bus_first_slot: got progclk=%b progen=%b, expected 0 01", bus3.progclk, bus3.progen);
        end
        for (k = 1; k < 400 && !got_done; k++) begin
            if (((bus3.progen !== prev_en) || (bus3.progdata !== prev_dat)) &&
                !(prev_clk === 1'b1 && bus3.progclk === 1'b0) && prev_busy === 1'b1)
                bad_change++;
            if (prev_clk === 1'b0 && bus3.progclk === 1'b1) begin
                if (last_rise >= 0 && (k - last_rise) != 6) bad_period++;
                last_rise = k;
                rises++;
            end
            if (bus3.progen !== 2'b00 && first_en < 0) first_en = k;
            if (bus3.progen === 2'b00 && prev_en !== 2'b00) last_en_fall = k;
            if (bus3.done === 1'b1) begin
                got_done = 1'b1;
                n_tests++;
                if (bus3.err !== 2'b00) begin
                    n_fail++;
                    $display("FAIL bus_done_err: got %b, expected 00", bus3.err);
                end
            end
            prev_clk = bus3.progclk; prev_dat = bus3.progdata; prev_en = bus3.progen; prev_busy = bus3.busy;
            if (!got_done) @(negedge IFCLK);
        end
        n_tests++;
        if (!got_done) begin
            n_fail++;
            $display("FAIL bus_done_wait: got no done in %0d cycles, expected done", k);
        end
        n_tests++;
        if (bad_change != 0) begin
            n_fail++;
            $display("FAIL bus_change_edge: got %0d changes off progclk falling edges, expected 0", bad_change);
        end
        n_tests++;
        if (bad_period != 0 || rises != 27) begin
            n_fail++;
            $display("FAIL bus_progclk_period: got %0d bad periods %0d rises, expected 0 27", bad_period, rises);
        end
        n_tests++;
        if (last_en_fall - first_en != 138) begin
            n_fail++;
            $display("FAIL bus_program_time: got %0d cycles, expected 138", last_en_fall - first_en);
        end
    endtask

    initial begin
        test_reset();
        test_nominal(2'd0, 8'h1B, 8'h03);
        test_nominal(2'd1, 8'hA5, 8'hFF);
        test_reject();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_bus_timing();
        repeat (5) @(negedge IFCLK);
        n_tests++;
        if (exp_bits_q.size() != 0 || exp_err_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d bits %0d codes left, expected 0 0",
                     exp_bits_q.size(), exp_err_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
